// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file sequencer: op encodings,
// FSM states, default geometry and the stack-pointer register index.
package rf_seq_pkg;

  localparam int AW_DEF      = 5;
  localparam int DW_DEF      = 8;
  localparam int SP_ADDR_DEF = 29;

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_SWAP = 2'b01,
    OP_INC  = 2'b10,
    OP_DEC  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    DONE = 3'd5
  } state_e;

  // SWAP is the only op that uses the second read and second write.
  function automatic logic is_swap(input logic [1:0] op);
    return (op == OP_SWAP);
  endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational data path for the sequencer: pass-through (MOV/SWAP),
// increment and decrement modulo 2^DW. carry is bit DW of the add/subtract.
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [1:0]    op,
  input  logic [DW-1:0] a,
  output logic [DW-1:0] y,
  output logic          carry
);

  logic [DW:0] sum_s;
  logic [DW:0] diff_s;

  // Extended add/subtract so the wrap/borrow lands in bit DW.
  always_comb begin
    sum_s  = {1'b0, a} + {{DW{1'b0}}, 1'b1};
    diff_s = {1'b0, a} - {{DW{1'b0}}, 1'b1};
  end

  // Select the write data and carry for the decoded operation.
  always_comb begin
    y     = a;
    carry = 1'b0;
    case (op)
      OP_INC: begin
        y     = sum_s[DW-1:0];
        carry = sum_s[DW];
      end
      OP_DEC: begin
        y     = diff_s[DW-1:0];
        carry = diff_s[DW];
      end
      default: begin
        y     = a;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rf_sequencer.sv
// Register-file sequencer: accepts one MOV/SWAP/INC/DEC command at a time
// and drives the shared register-file port with a read/write sequence.
// Optional feature: define RF_SEQ_SP_GUARD_EN to refuse any command that
// would write the stack-pointer register (SP_ADDR).
module rf_sequencer
  import rf_seq_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int SP_ADDR = SP_ADDR_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          err,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_we,
  input  logic [DW-1:0] rf_rdata
);

  localparam logic [AW-1:0] SP_IDX = AW'(SP_ADDR);

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [DW-1:0] tmp_a_q, tmp_a_d;
  logic [DW-1:0] tmp_b_q, tmp_b_d;
  logic [DW-1:0] pend_res_q, pend_res_d;
  logic          pend_carry_q, pend_carry_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] result_q, result_d;
  logic          carry_q, carry_d;
  logic          rf_we_q, rf_we_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;

  logic          accept_s;
  logic          guard_s;
  logic [DW-1:0] alu_in_s;
  logic [DW-1:0] alu_y_s;
  logic          alu_c_s;

  // Refusal check on the incoming command's write targets.
  always_comb begin
`ifdef RF_SEQ_SP_GUARD_EN
    guard_s = (cmd_dst == SP_IDX) || (is_swap(cmd_op) && (cmd_src == SP_IDX));
`else
    guard_s = 1'b0;
`endif
  end

  // In RD_A the first operand is still on rf_rdata; later it sits in tmp_a.
  always_comb begin
    accept_s = cmd_valid && (state_q == IDLE);
    if (state_q == RD_A) begin
      alu_in_s = rf_rdata;
    end else begin
      alu_in_s = tmp_a_q;
    end
  end

  rf_seq_alu #(.DW(DW)) u_alu (
    .op    (op_q),
    .a     (alu_in_s),
    .y     (alu_y_s),
    .carry (alu_c_s)
  );

  // Port address decodes only from state and the latched src/dst.
  always_comb begin
    case (state_q)
      RD_A:    rf_addr = src_q;
      RD_B:    rf_addr = dst_q;
      WR_A:    rf_addr = dst_q;
      WR_B:    rf_addr = src_q;
      default: rf_addr = {AW{1'b0}};
    endcase
  end

  // Next-state and next-output computation for the command sequence.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    src_d        = src_q;
    dst_d        = dst_q;
    tmp_a_d      = tmp_a_q;
    tmp_b_d      = tmp_b_q;
    pend_res_d   = pend_res_q;
    pend_carry_d = pend_carry_q;
    done_d       = 1'b0;
    err_d        = err_q;
    result_d     = result_q;
    carry_d      = carry_q;
    rf_we_d      = 1'b0;
    rf_wdata_d   = rf_wdata_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d  = cmd_op;
          src_d = cmd_src;
          dst_d = cmd_dst;
          if (guard_s) begin
            // Refused: report straight away, nothing touches the port.
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = RD_A;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_A: begin
        tmp_a_d = rf_rdata;
        if (is_swap(op_q)) begin
          state_d = RD_B;
        end else begin
          state_d      = WR_A;
          rf_we_d      = 1'b1;
          rf_wdata_d   = alu_y_s;
          pend_res_d   = alu_y_s;
          pend_carry_d = alu_c_s;
        end
      end
      RD_B: begin
        tmp_b_d      = rf_rdata;
        state_d      = WR_A;
        rf_we_d      = 1'b1;
        rf_wdata_d   = alu_y_s;
        pend_res_d   = alu_y_s;
        pend_carry_d = alu_c_s;
      end
      WR_A: begin
        if (is_swap(op_q)) begin
          state_d    = WR_B;
          rf_we_d    = 1'b1;
          rf_wdata_d = tmp_b_q;
        end else begin
          state_d  = DONE;
          done_d   = 1'b1;
          err_d    = 1'b0;
          result_d = pend_res_q;
          carry_d  = pend_carry_q;
        end
      end
      WR_B: begin
        state_d  = DONE;
        done_d   = 1'b1;
        err_d    = 1'b0;
        result_d = pend_res_q;
        carry_d  = pend_carry_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset aborts any write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      src_q        <= {AW{1'b0}};
      dst_q        <= {AW{1'b0}};
      tmp_a_q      <= {DW{1'b0}};
      tmp_b_q      <= {DW{1'b0}};
      pend_res_q   <= {DW{1'b0}};
      pend_carry_q <= 1'b0;
      cmd_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      result_q     <= {DW{1'b0}};
      carry_q      <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_wdata_q   <= {DW{1'b0}};
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      tmp_a_q      <= tmp_a_d;
      tmp_b_q      <= tmp_b_d;
      pend_res_q   <= pend_res_d;
      pend_carry_q <= pend_carry_d;
      cmd_ready_q  <= cmd_ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      rf_we_q      <= rf_we_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign rf_we     = rf_we_q;
  assign rf_wdata  = rf_wdata_q;

endmodule
